// File: rtl/tsn_str_pkg.sv
// tsn_str_pkg: shared TSN stream types, width defaults and TKEEP helpers.
package tsn_str_pkg;
  localparam int TSN_DATA_W    = 32;
  localparam int TSN_KEEP_W    = TSN_DATA_W / 8;
  localparam int TSN_MAX_BEATS = 1024;
  localparam int TSN_CNT_W     = 11;
  localparam int TSN_BCNT_W    = $clog2(TSN_KEEP_W + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_FLUSH} arb_state_t;
  function automatic logic [TSN_BCNT_W-1:0] keep_bytes(input logic [TSN_KEEP_W-1:0] keep);
    return TSN_BCNT_W'($countones(keep));
  endfunction
endpackage

// File: rtl/tsn_str_pkt_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-requester round-robin picker.
module rr_arb2
  import tsn_str_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       gnt_vld
);
  assign grant   = &req ? ~last_grant : req[1];
  assign gnt_vld = |req;
endmodule

// File: rtl/tsn_str_pkt_arbiter.sv
// tsn_str_pkt_arbiter: packet-level 2:1 AXI4-Stream arbiter with a beat watchdog
// that forces TLAST at MAX_BEATS and flushes the remainder of the offending packet.
module tsn_str_pkt_arbiter
  import tsn_str_pkg::*;
#(
  parameter int DATA_W    = TSN_DATA_W,
  parameter int KEEP_W    = TSN_KEEP_W,
  parameter int MAX_BEATS = TSN_MAX_BEATS,
  parameter int CNT_W     = TSN_CNT_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [DATA_W-1:0] S0_TDATA,
  input  logic [KEEP_W-1:0] S0_TKEEP,
  input  logic              S0_TLAST,
  input  logic              S0_TUSER,
  input  logic              S0_TVALID,
  output logic              S0_TREADY,
  input  logic [DATA_W-1:0] S1_TDATA,
  input  logic [KEEP_W-1:0] S1_TKEEP,
  input  logic              S1_TLAST,
  input  logic              S1_TUSER,
  input  logic              S1_TVALID,
  output logic              S1_TREADY,
  output logic [DATA_W-1:0] M_TDATA,
  output logic [KEEP_W-1:0] M_TKEEP,
  output logic              M_TLAST,
  output logic              M_TUSER,
  output logic              M_TVALID,
  input  logic              M_TREADY,
  output logic              GRANT_ID,
  output logic              GRANT_VLD,
  output logic              TRUNC_ERR
);
  localparam logic [CNT_W-1:0] WD_CNT = CNT_W'(MAX_BEATS - 1);
  arb_state_t        state;
  logic              gnt, last_grant, pick, pick_vld;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] s_tdata;
  logic [KEEP_W-1:0] s_tkeep;
  logic              s_tlast, s_tuser, s_tvalid;
  logic              xfer, flush, wd_hit, beat, end_pkt;
  rr_arb2 u_rr (
    .req        ({S1_TVALID, S0_TVALID}),
    .last_grant (last_grant),
    .grant      (pick),
    .gnt_vld    (pick_vld)
  );
  assign xfer     = state == ST_XFER;
  assign flush    = state == ST_FLUSH;
  assign s_tdata  = gnt ? S1_TDATA  : S0_TDATA;
  assign s_tkeep  = gnt ? S1_TKEEP  : S0_TKEEP;
  assign s_tlast  = gnt ? S1_TLAST  : S0_TLAST;
  assign s_tuser  = gnt ? S1_TUSER  : S0_TUSER;
  assign s_tvalid = gnt ? S1_TVALID : S0_TVALID;
  assign wd_hit   = beat_cnt == WD_CNT;
  assign beat     = xfer & s_tvalid & M_TREADY;
  assign end_pkt  = s_tlast | wd_hit;
  assign M_TDATA  = xfer ? s_tdata : '0;
  assign M_TKEEP  = xfer ? s_tkeep : '0;
  assign M_TUSER  = xfer & s_tuser;
  assign M_TLAST  = xfer & end_pkt;
  assign M_TVALID = xfer & s_tvalid;
  // in FLUSH the granted source is drained unconditionally, the other stays blocked
  assign S0_TREADY = ~gnt & (xfer ? M_TREADY : flush);
  assign S1_TREADY =  gnt & (xfer ? M_TREADY : flush);
  assign GRANT_ID  = gnt;
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      GRANT_VLD  <= 1'b0;
      TRUNC_ERR  <= 1'b0;
    end else begin
      TRUNC_ERR <= 1'b0;
      unique case (state)
        ST_IDLE: if (pick_vld) begin
          gnt       <= pick;
          state     <= ST_XFER;
          GRANT_VLD <= 1'b1;
        end
        ST_XFER: if (beat) begin
          beat_cnt <= end_pkt ? '0 : beat_cnt + 1'b1;
          if (end_pkt) begin
            last_grant <= gnt;
            GRANT_VLD  <= 1'b0;
            TRUNC_ERR  <= ~s_tlast;
            state      <= s_tlast ? ST_IDLE : ST_FLUSH;
          end
        end
        ST_FLUSH: if (s_tvalid && s_tlast) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tsn_str_pkt_arbiter.sv
// tb_tsn_str_pkt_arbiter: directed bench for the packet arbiter (MAX_BEATS=8).
module tb_tsn_str_pkt_arbiter;
  logic        CLK = 1'b0, RSTN = 1'b0;
  logic [31:0] S0_TDATA, S1_TDATA, M_TDATA;
  logic [3:0]  S0_TKEEP, S1_TKEEP, M_TKEEP;
  logic        S0_TLAST, S0_TUSER, S0_TVALID, S0_TREADY;
  logic        S1_TLAST, S1_TUSER, S1_TVALID, S1_TREADY;
  logic        M_TLAST, M_TUSER, M_TVALID, M_TREADY;
  logic        GRANT_ID, GRANT_VLD, TRUNC_ERR;
  int total = 0, bad = 0;
  int c = 0, b0 = 0, b1 = 0, p0 = 0, p1 = 0, len0 = 1, len1 = 1, np0 = 0, np1 = 0;
  bit en0 = 0, en1 = 0, tr_mode = 0, mirror = 0, h0, h1;
  bit gv[64], gi[64], te[64], mv[64], r1[64];
  logic [31:0] bd[$];
  logic [3:0]  bk[$];
  bit          bl[$], bu[$];
  int          bc[$];

  tsn_str_pkt_arbiter #(.MAX_BEATS(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .S0_TDATA(S0_TDATA), .S0_TKEEP(S0_TKEEP), .S0_TLAST(S0_TLAST), .S0_TUSER(S0_TUSER),
    .S0_TVALID(S0_TVALID), .S0_TREADY(S0_TREADY),
    .S1_TDATA(S1_TDATA), .S1_TKEEP(S1_TKEEP), .S1_TLAST(S1_TLAST), .S1_TUSER(S1_TUSER),
    .S1_TVALID(S1_TVALID), .S1_TREADY(S1_TREADY),
    .M_TDATA(M_TDATA), .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TUSER(M_TUSER),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
    .GRANT_ID(GRANT_ID), .GRANT_VLD(GRANT_VLD), .TRUNC_ERR(TRUNC_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    S0_TVALID = en0 && p0 < np0;
    S0_TDATA  = {8'h50, 8'(p0), 16'(b0)};
    S0_TLAST  = b0 == len0 - 1;
    S0_TUSER  = b0 == 0;
    S0_TKEEP  = 4'hF;
    S1_TVALID = en1 && p1 < np1;
    S1_TDATA  = {8'h51, 8'(p1), 16'(b1)};
    S1_TLAST  = b1 == len1 - 1;
    S1_TUSER  = b1 == 0;
    S1_TKEEP  = 4'h3;
    M_TREADY  = tr_mode ? c[0] : 1'b1;
  endtask

  task automatic step();
    drive();
    #2;
    gv[c] = GRANT_VLD; gi[c] = GRANT_ID; te[c] = TRUNC_ERR; mv[c] = M_TVALID; r1[c] = S1_TREADY;
    if (mirror && GRANT_VLD) begin
      chk($sformatf("t3_s1_rdy_c%0d", c), S1_TREADY, M_TREADY);
      chk($sformatf("t3_s0_rdy_c%0d", c), S0_TREADY, 1'b0);
    end
    h0 = S0_TVALID && S0_TREADY;
    h1 = S1_TVALID && S1_TREADY;
    if (M_TVALID && M_TREADY) begin
      bd.push_back(M_TDATA); bk.push_back(M_TKEEP); bl.push_back(M_TLAST);
      bu.push_back(M_TUSER); bc.push_back(c);
    end
    @(posedge CLK); #1;
    if (h0) begin if (b0 == len0 - 1) begin b0 = 0; p0++; end else b0++; end
    if (h1) begin if (b1 == len1 - 1) begin b1 = 0; p1++; end else b1++; end
    c++;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    en0 = 0; en1 = 0; tr_mode = 0; mirror = 0;
    b0 = 0; b1 = 0; p0 = 0; p1 = 0; c = 0;
    drive();
    repeat (2) @(posedge CLK);
    #1;
    bd.delete(); bk.delete(); bl.delete(); bu.delete(); bc.delete();
    RSTN = 1'b1;
  endtask

  task automatic chk_beat(input string t, input int i, input logic [31:0] d, input bit l,
                          input bit u, input logic [3:0] k, input int cyc);
    if (i >= bd.size()) chk($sformatf("%s_beat%0d_missing", t, i), bd.size(), i + 1);
    else begin
      chk($sformatf("%s_b%0d_data", t, i), bd[i], d);
      chk($sformatf("%s_b%0d_last", t, i), bl[i], l);
      chk($sformatf("%s_b%0d_user", t, i), bu[i], u);
      chk($sformatf("%s_b%0d_keep", t, i), bk[i], k);
      chk($sformatf("%s_b%0d_cyc", t, i), bc[i], cyc);
    end
  endtask

  initial begin
    drive();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_gvld", GRANT_VLD, 0);
    chk("rst_gid", GRANT_ID, 0);
    chk("rst_trunc", TRUNC_ERR, 0);
    chk("rst_mvalid", M_TVALID, 0);
    chk("rst_mdata", M_TDATA, 0);
    chk("rst_s0rdy", S0_TREADY, 0);
    chk("rst_s1rdy", S1_TREADY, 0);

    // 1: single 4-beat packet from S0
    do_reset();
    en0 = 1; np0 = 1; len0 = 4;
    repeat (6) step();
    chk("t1_gv_c0", gv[0], 0);
    chk("t1_gv_c1", gv[1], 1);
    chk("t1_gid_c1", gi[1], 0);
    chk("t1_nbeats", bd.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_beat("t1", i, 32'h5000_0000 + i, i == 3, i == 0, 4'hF, i + 1);
    chk("t1_gv_c5", gv[5], 0);
    chk("t1_mv_c5", mv[5], 0);

    // 2: both requesters always valid, 2-beat packets alternate with one idle cycle
    do_reset();
    en0 = 1; en1 = 1; np0 = 2; np1 = 2; len0 = 2; len1 = 2;
    repeat (13) step();
    chk("t2_nbeats", bd.size(), 8);
    for (int i = 0; i < 8; i++) begin
      int s, p, b;
      s = (i / 2) % 2; p = i / 4; b = i % 2;
      chk_beat("t2", i, {8'h50 + 8'(s), 8'(p), 16'(b)}, b == 1, b == 0,
               s ? 4'h3 : 4'hF, 1 + 3 * (i / 2) + b);
    end
    chk("t2_gid_c4", gi[4], 1);

    // 3: M_TREADY toggling during an S1 packet
    do_reset();
    en1 = 1; np1 = 1; len1 = 3; tr_mode = 1; mirror = 1;
    repeat (7) step();
    mirror = 0; tr_mode = 0;
    chk("t3_nbeats", bd.size(), 3);
    for (int i = 0; i < 3; i++)
      chk_beat("t3", i, 32'h5100_0000 + i, i == 2, i == 0, 4'h3, 2 * i + 1);

    // 4: 12-beat S0 packet is cut at 8, remainder flushed, then S1 served
    do_reset();
    en0 = 1; en1 = 1; np0 = 1; np1 = 1; len0 = 12; len1 = 2;
    repeat (17) step();
    chk("t4_nbeats", bd.size(), 10);
    for (int i = 0; i < 8; i++)
      chk_beat("t4", i, 32'h5000_0000 + i, i == 7, i == 0, 4'hF, i + 1);
    chk_beat("t4", 8, 32'h5100_0000, 0, 1, 4'h3, 14);
    chk_beat("t4", 9, 32'h5100_0001, 1, 0, 4'h3, 15);
    chk("t4_te_c8", te[8], 0);
    chk("t4_te_c9", te[9], 1);
    chk("t4_te_c10", te[10], 0);
    for (int i = 9; i <= 12; i++) chk($sformatf("t4_mv_c%0d", i), mv[i], 0);
    chk("t4_s1_held_c10", r1[10], 0);
    chk("t4_s0_drained", p0, 1);
    chk("t4_gid_c14", gi[14], 1);

    // 5: exactly MAX_BEATS with real TLAST is not truncated
    do_reset();
    en0 = 1; np0 = 1; len0 = 8;
    repeat (10) step();
    chk("t5_nbeats", bd.size(), 8);
    chk_beat("t5", 7, 32'h5000_0007, 1, 0, 4'hF, 8);
    begin
      int s;
      s = 0;
      for (int i = 0; i < 10; i++) s += te[i];
      chk("t5_no_trunc", s, 0);
    end
    chk("t5_gv_c9", gv[9], 0);

    // 6: async reset during beat 3 of an S1 packet
    do_reset();
    en1 = 1; np1 = 1; len1 = 6;
    repeat (3) step();
    drive();
    #1;
    chk("t6_pre_mvalid", M_TVALID, 1);
    RSTN = 1'b0;
    #1;
    chk("t6_rst_mvalid", M_TVALID, 0);
    chk("t6_rst_mdata", M_TDATA, 0);
    chk("t6_rst_mlast", M_TLAST, 0);
    chk("t6_rst_s1rdy", S1_TREADY, 0);
    chk("t6_rst_gvld", GRANT_VLD, 0);
    repeat (2) @(posedge CLK);
    #1;
    b1 = 0; c = 0;
    en0 = 1; np0 = 1; len0 = 1;
    drive();
    RSTN = 1'b1;
    repeat (2) step();
    chk("t6_gv_c1", gv[1], 1);
    chk("t6_gid_c1", gi[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
